// File: rtl/repeated_sub_divider_pkg.sv
// Shared types and constants for the repeated-subtraction divider.
package repeated_sub_divider_pkg;

    localparam int DIV_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_B = 2'd1,
        CALC   = 2'd2,
        DONE   = 2'd3
    } div_state_t;

endpackage : repeated_sub_divider_pkg

// File: rtl/repeated_sub_divider_div_datapath.sv
// Divider datapath: the remainder, divisor and quotient registers, plus the
// comparator, subtractor and zero-detect that the control FSM needs.
module div_datapath
    import repeated_sub_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_a,    // capture dividend into remainder, clear quotient
    input  logic             load_b,    // capture divisor
    input  logic             sub_en,    // remainder <= remainder - divisor
    input  logic             inc_en,    // quotient <= quotient + 1
    input  logic             sat_en,    // quotient <= all-ones (divide by zero)
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             ge,        // remainder >= divisor
    output logic             dz         // divisor == 0
);

    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic [WIDTH-1:0] divisor_q,   divisor_d;
    logic [WIDTH-1:0] quotient_q,  quotient_d;

    // Status seen by the FSM; both come straight from registers.
    always_comb begin
        ge = (remainder_q >= divisor_q);
        dz = (divisor_q == '0);
    end

    // Next-value selection for the three working registers.
    always_comb begin
        remainder_d = remainder_q;
        divisor_d   = divisor_q;
        quotient_d  = quotient_q;
        if (load_a) begin
            remainder_d = data_in;
            quotient_d  = '0;
        end
        if (load_b) begin
            divisor_d = data_in;
        end
        // The FSM only asserts sub_en when ge is true, so this never wraps.
        if (sub_en) begin
            remainder_d = remainder_q - divisor_q;
        end
        if (inc_en) begin
            quotient_d = quotient_q + 1'b1;
        end
        if (sat_en) begin
            quotient_d = '1;
        end
    end

    // Register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            remainder_q <= '0;
            divisor_q   <= '0;
            quotient_q  <= '0;
        end else begin
            remainder_q <= remainder_d;
            divisor_q   <= divisor_d;
            quotient_q  <= quotient_d;
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;

endmodule : div_datapath

// File: rtl/repeated_sub_divider.sv
// Unsigned divider by repeated subtraction. Dividend and divisor arrive on
// consecutive cycles over data_in; one subtraction is attempted per cycle.
module repeated_sub_divider
    import repeated_sub_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    div_state_t state_q, state_d;
    logic       dbz_q, dbz_d;

    logic load_a, load_b, sub_en, inc_en, sat_en;
    logic ge, dz;
    logic accept;

    // A new operation can only be accepted from IDLE or DONE.
    assign accept = start && ((state_q == IDLE) || (state_q == DONE));

    div_datapath #(
        .WIDTH (WIDTH)
    ) u_datapath (
        .clk       (clk),
        .rst       (rst),
        .load_a    (load_a),
        .load_b    (load_b),
        .sub_en    (sub_en),
        .inc_en    (inc_en),
        .sat_en    (sat_en),
        .data_in   (data_in),
        .quotient  (quotient),
        .remainder (remainder),
        .ge        (ge),
        .dz        (dz)
    );

    // State and divide-by-zero flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dbz_q   <= dbz_d;
        end
    end

    // Next-state logic; any unexpected encoding falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start ? LOAD_B : IDLE;
            LOAD_B:  state_d = CALC;
            CALC: begin
                if (dz)      state_d = DONE;
                else if (ge) state_d = CALC;
                else         state_d = DONE;
            end
            DONE:    state_d = start ? LOAD_B : DONE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath strobe decode from the registered state.
    always_comb begin
        load_a = accept;
        load_b = (state_q == LOAD_B);
        sub_en = (state_q == CALC) && !dz && ge;
        inc_en = sub_en;
        sat_en = (state_q == CALC) && dz;
        busy   = (state_q == LOAD_B) || (state_q == CALC);
        done   = (state_q == DONE);
    end

    // dbz is cleared by an accepted start and set when CALC sees a zero divisor.
    always_comb begin
        dbz_d = dbz_q;
        if (accept) dbz_d = 1'b0;
        if (sat_en) dbz_d = 1'b1;
    end

    assign dbz = dbz_q;

endmodule : repeated_sub_divider

// File: doc/repeated_sub_divider.md
Name: repeated_sub_divider

Overview:
- Unsigned integer divider by repeated subtraction; the inverse of the team's repeated-addition multiplier.
- Operands arrive in sequence on one shared data_in bus: dividend first, divisor on the next cycle.
- Control FSM and datapath (remainder register, quotient counter, comparator, subtractor) produce quotient, remainder, a done flag and a divide-by-zero flag.
- Sits beside the multiplier as the arithmetic unit for divide operations.

Parameters:
- WIDTH, 16, operand/result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- data_in  input  WIDTH  shared operand bus: dividend in the start cycle, divisor in the following cycle.
- quotient  output  WIDTH  working quotient register; valid only while done=1.
- remainder  output  WIDTH  working remainder register; valid only while done=1.
- busy  output  1  high in LOAD_B and CALC.
- done  output  1  high in DONE; held until the next accepted start or rst.
- dbz  output  1  divide-by-zero flag; valid with done; cleared on the next accepted start.

Behaviour:
- Reset: rst=1 at a clock edge forces state=IDLE and quotient=remainder=divisor_reg=0, busy=done=dbz=0. This takes priority over every other input, including mid-operation; any in-flight result is discarded.
- All outputs are registered or decoded from the registered state. No combinational path from start or data_in to any output.
- IDLE: if start=1, then remainder<=data_in, quotient<=0, dbz<=0, state->LOAD_B. Otherwise hold.
- LOAD_B: divisor_reg<=data_in, state->CALC. start is ignored.
- CALC, one decision per cycle:
  - divisor_reg==0: quotient<=all-ones, remainder is held (equals the dividend), dbz<=1, state->DONE.
  - remainder>=divisor_reg: remainder<=remainder-divisor_reg, quotient<=quotient+1, stay in CALC.
  - otherwise: state->DONE.
  - start is ignored in CALC.
- DONE: done=1 and results are held. If start=1, the edge behaves exactly as IDLE with start=1 (new dividend captured, state->LOAD_B, done drops on the next cycle).
- Latency, counting edge E0 as the edge that accepts start:
  - Divisor is sampled at E1.
  - For nonzero divisor, done=1 after edge E(q+2), where q is the final quotient.
  - For zero divisor, done=1 after E2.
  - Worst case is 65535/1: 65537 cycles.
- Arithmetic:
  - Unsigned throughout.
  - Subtraction is performed only when remainder>=divisor_reg, so it never underflows.
  - quotient never exceeds the dividend, so no overflow or wrap.
  - Final remainder is strictly less than the divisor.
- Boundaries:
  - Dividend 0 with nonzero divisor: q=0, r=0, done after E2.
  - Dividend equal to divisor: q=1, r=0.
  - Dividend less than divisor: q=0, r=dividend.
- State encoding is 2-bit (IDLE=0, LOAD_B=1, CALC=2, DONE=3). An unreachable or illegal state recovers to IDLE on the next edge.

Decomposition:
- Shared package holds:
  - state typedef (IDLE, LOAD_B, CALC, DONE);
  - DIV_WIDTH default constant = 16.
- One natural sub-module, div_datapath:
  - contents: remainder register, divisor register, quotient counter, >= comparator, subtractor, zero-detect;
  - exports: ge and dz status;
  - controlled by load/sub/inc/clear strobes.
- The top level holds the FSM and instantiates div_datapath.

Test Plan:
- 100/7: start with data_in=100, then 7 -> done rises after E16, quotient=14, remainder=2, dbz=0, busy low from E16.
- 5/9 -> done after E2, quotient=0, remainder=5.
- 42/0 -> done after E2, dbz=1, quotient=16'hFFFF, remainder=42. A following 6/3 run clears dbz, giving q=2, r=0.
- 65535/65535 -> q=1, r=0 after E3. Also 65535/1 -> q=65535, r=0 after E65537.
- Pulse start during CALC of 100/7 -> ignored, same result and latency. start held high in DONE -> back-to-back run accepted, done low for exactly the run duration.
- Assert rst during CALC -> next cycle state IDLE, all outputs 0. A new 20/6 run gives q=3, r=2.
